// File: rtl/fetch_unit.sv
// Fetch stage: sequences the word-addressed program counter into the
// instruction memory and pairs the memory's registered output with its PC.
// Supports hazard stall and zero-bubble branch/jump redirect.
module fetch_unit #(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned INSTR_W    = 32,
  parameter int unsigned IMEM_DEPTH = 40,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic               if_valid,
  output logic               if_oob
);

  localparam logic [ADDR_W-1:0] RESET_PC_W = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(1);

  // fetch_pc: next address to request.
  // head_pc:  address requested at the previous edge; its data is on imem_instr now.
  // head_v:   head_pc refers to a real request (cleared by reset).
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] head_pc_q,  head_pc_d;
  logic              head_v_q,   head_v_d;

  // Next-state and memory address: redirect beats stall beats sequential fetch.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    fetch_pc_d = fetch_pc_q;
    head_pc_d  = head_pc_q;
    head_v_d   = head_v_q;
    imem_addr  = fetch_pc_q;
    if (redirect_valid) begin
      imem_addr  = redirect_pc;
      head_pc_d  = redirect_pc;
      head_v_d   = 1'b1;
      fetch_pc_d = redirect_pc + PC_STEP;
    end else if (stall) begin
      // Re-read the in-flight address so imem_instr stays aligned with head_pc.
      imem_addr = head_pc_q;
    end else begin
      head_pc_d  = fetch_pc_q;
      head_v_d   = 1'b1;
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end
  end

  // State registers with synchronous reset; reset overrides stall and redirect.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge
    // values, independent of statement order.
    if (rst) begin
      fetch_pc_q <= RESET_PC_W;
      head_pc_q  <= RESET_PC_W;
      head_v_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_pc_q  <= head_pc_d;
      head_v_q   <= head_v_d;
    end
  end

  // Decode-facing outputs; a redirect squashes the (wrong-path) head in the same cycle.
  always_comb begin
    if_pc    = head_pc_q;
    if_instr = imem_instr;
    if_oob   = head_v_q & (32'(head_pc_q) >= IMEM_DEPTH) & ~rst;
    if_valid = head_v_q & ~if_oob & ~redirect_valid & ~rst;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a registered instruction-memory model,
// a cycle-level reference model feeding a scoreboard queue, and directed
// checks for stall, redirect, out-of-range, wrap and reset scenarios.
module tb_fetch_unit;

  localparam int ADDR_W  = 11;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 40;

  logic               clk = 1'b0;
  logic               rst;
  logic               stall;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic [ADDR_W-1:0]  if_pc;
  logic [INSTR_W-1:0] if_instr;
  logic               if_valid;
  logic               if_oob;

  fetch_unit #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .IMEM_DEPTH(DEPTH), .RESET_PC(0)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .if_pc(if_pc), .if_instr(if_instr),
    .if_valid(if_valid), .if_oob(if_oob)
  );

  always #5 clk = ~clk;

  // Memory contents: mem[i] = i + 0x100 for populated words.
  function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    if (int'(a) < DEPTH) return 32'h100 + 32'(a);
    return 32'hDEAD_0000 | 32'(a);
  endfunction

  // Registered (1-cycle latency) instruction memory.
  always @(posedge clk) imem_instr <= mem_word(imem_addr);

  typedef struct {
    logic [ADDR_W-1:0]  addr;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
    logic               valid;
    logic               oob;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state.
  logic [ADDR_W-1:0] m_fetch, m_head;
  logic              m_hv;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive inputs at negedge, push the expectation, update the model,
  // then pop and compare against the settled DUT outputs before the next posedge.
  task automatic step(input logic r, input logic s, input logic rv, input logic [ADDR_W-1:0] rpc);
    exp_t e;
    @(negedge clk);
    rst = r; stall = s; redirect_valid = rv; redirect_pc = rpc;
    e.addr  = rv ? rpc : (s ? m_head : m_fetch);
    e.oob   = m_hv && (int'(m_head) >= DEPTH) && !r;
    e.valid = m_hv && !e.oob && !rv && !r;
    e.pc    = m_head;
    e.instr = mem_word(m_head);
    sb.push_back(e);
    if (r) begin
      m_fetch = '0; m_head = '0; m_hv = 1'b0;
    end else if (rv) begin
      m_head = rpc; m_hv = 1'b1; m_fetch = rpc + 11'd1;
    end else if (!s) begin
      m_head = m_fetch; m_hv = 1'b1; m_fetch = m_fetch + 11'd1;
    end
    #1;
    if (sb.size() == 0) begin
      check("sb_underflow", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check("sb_addr",  64'(imem_addr), 64'(e.addr));
      check("sb_valid", 64'(if_valid),  64'(e.valid));
      check("sb_oob",   64'(if_oob),    64'(e.oob));
      check("sb_pc",    64'(if_pc),     64'(e.pc));
      if (e.valid) check("sb_instr", 64'(if_instr), 64'(e.instr));
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    m_fetch = '0; m_head = '0; m_hv = 1'b0;

    // Reset state and free run.
    step(1'b1, 1'b0, 1'b0, '0);
    check("rst_valid", 64'(if_valid), 64'd0);
    check("rst_oob",   64'(if_oob),   64'd0);
    check("rst_addr",  64'(imem_addr), 64'd0);
    step(1'b0, 1'b0, 1'b0, '0);
    check("post_rst_valid", 64'(if_valid), 64'd0);
    check("post_rst_addr",  64'(imem_addr), 64'd0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b0, '0);
      check("run_pc",    64'(if_pc),     64'(i));
      check("run_instr", 64'(if_instr),  64'(32'h100 + i));
      check("run_valid", 64'(if_valid),  64'd1);
      check("run_addr",  64'(imem_addr), 64'(i + 1));
    end

    // Stall for 3 cycles while pc = 2.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, '0);
      check("stall_pc",    64'(if_pc),     64'd2);
      check("stall_instr", 64'(if_instr),  64'h102);
      check("stall_valid", 64'(if_valid),  64'd1);
      check("stall_addr",  64'(imem_addr), 64'd2);
    end
    for (int i = 2; i <= 4; i++) begin
      step(1'b0, 1'b0, 1'b0, '0);
      check("release_pc", 64'(if_pc), 64'(i));
    end

    // Redirect to 20 while pc = 5.
    step(1'b0, 1'b0, 1'b1, 11'd20);
    check("redir_pc_old", 64'(if_pc),     64'd5);
    check("redir_squash", 64'(if_valid),  64'd0);
    check("redir_addr",   64'(imem_addr), 64'd20);
    step(1'b0, 1'b0, 1'b0, '0);
    check("redir_tgt_pc",    64'(if_pc),    64'd20);
    check("redir_tgt_instr", 64'(if_instr), 64'h114);
    check("redir_tgt_valid", 64'(if_valid), 64'd1);
    step(1'b0, 1'b0, 1'b0, '0);
    check("redir_next_pc", 64'(if_pc), 64'd21);

    // Redirect and stall together: redirect wins.
    step(1'b0, 1'b1, 1'b1, 11'd7);
    check("rs_addr", 64'(imem_addr), 64'd7);
    step(1'b0, 1'b0, 1'b0, '0);
    check("rs_pc",    64'(if_pc),     64'd7);
    check("rs_valid", 64'(if_valid),  64'd1);
    check("rs_addr2", 64'(imem_addr), 64'd8);

    // Run off the end of the populated memory, then redirect back.
    step(1'b0, 1'b0, 1'b1, 11'd38);
    step(1'b0, 1'b0, 1'b0, '0);
    check("end38_valid", 64'(if_valid), 64'd1);
    step(1'b0, 1'b0, 1'b0, '0);
    check("end39_pc",    64'(if_pc),    64'd39);
    check("end39_oob",   64'(if_oob),   64'd0);
    step(1'b0, 1'b0, 1'b0, '0);
    check("oob40_pc",    64'(if_pc),    64'd40);
    check("oob40_oob",   64'(if_oob),   64'd1);
    check("oob40_valid", 64'(if_valid), 64'd0);
    step(1'b0, 1'b0, 1'b1, 11'd0);
    check("oob41_oob",   64'(if_oob),   64'd1);
    step(1'b0, 1'b0, 1'b0, '0);
    check("oob_clr_oob",   64'(if_oob),   64'd0);
    check("oob_clr_valid", 64'(if_valid), 64'd1);
    check("oob_clr_instr", 64'(if_instr), 64'h100);

    // Address wrap at 2^ADDR_W - 1.
    step(1'b0, 1'b0, 1'b1, 11'd2047);
    step(1'b0, 1'b0, 1'b0, '0);
    check("wrap_pc",   64'(if_pc),     64'd2047);
    check("wrap_oob",  64'(if_oob),    64'd1);
    check("wrap_addr", 64'(imem_addr), 64'd0);
    step(1'b0, 1'b0, 1'b0, '0);
    check("wrap0_pc",    64'(if_pc),    64'd0);
    check("wrap0_valid", 64'(if_valid), 64'd1);

    // Reset pulsed mid-stall at pc = 12.
    step(1'b0, 1'b0, 1'b1, 11'd12);
    step(1'b0, 1'b1, 1'b0, '0);
    check("pre_rst_pc", 64'(if_pc), 64'd12);
    step(1'b1, 1'b1, 1'b0, '0);
    check("mid_rst_valid", 64'(if_valid), 64'd0);
    step(1'b0, 1'b0, 1'b0, '0);
    check("after_rst_pc",   64'(if_pc),     64'd0);
    check("after_rst_addr", 64'(imem_addr), 64'd0);
    step(1'b0, 1'b0, 1'b0, '0);
    check("after_rst_first_pc",    64'(if_pc),    64'd0);
    check("after_rst_first_valid", 64'(if_valid), 64'd1);
    check("after_rst_first_instr", 64'(if_instr), 64'h100);

    // Random mix of stall, redirect and occasional reset against the model.
    for (int i = 0; i < 200; i++) begin
      logic r, s, rv;
      logic [ADDR_W-1:0] rpc;
      r   = ($urandom_range(0, 29) == 0);
      s   = ($urandom_range(0, 3) == 0);
      rv  = ($urandom_range(0, 5) == 0);
      rpc = ADDR_W'($urandom_range(0, 45));
      step(r, s, rv, rpc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
